// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and raster helpers.
// Also used by the board renderer for SCREEN_WIDTH/SCREEN_HEIGHT.
package vga_timing_pkg;

  localparam int unsigned VGA_CNT_W = 10;

  localparam int unsigned VGA_CLK_DIV = 2;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_H_TOTAL   =
      VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_V_TOTAL   =
      VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam logic VGA_HSYNC_POL = 1'b0;
  localparam logic VGA_VSYNC_POL = 1'b0;

  localparam int unsigned SCREEN_WIDTH  = VGA_H_VISIBLE;
  localparam int unsigned SCREEN_HEIGHT = VGA_V_VISIBLE;

  typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
  } vga_ctrl_t;

  // Inclusive window test on a raster counter.
  function automatic logic in_window(vga_cnt_t cnt, vga_cnt_t first, vga_cnt_t last);
    return (cnt >= first) && (cnt <= last);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: divides clk by CLK_DIV and pulses tick_o once per period.
module vga_pix_tick
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne = DivW'(1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;

  // With CLK_DIV == 1 the counter is stuck at 0 and tick_o is always high.
  always_comb begin
    div_cnt_d = div_cnt_q + DivOne;
    if (div_cnt_q == DivMax) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick_o = (div_cnt_q == DivMax);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, blank and syncs, all registered from the same next state.
// Optional VGA_TIMING_FRAME_CNT_EN adds an 8-bit wrapping frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic        HSYNC_POL = VGA_HSYNC_POL,
  parameter logic        VSYNC_POL = VGA_VSYNC_POL
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [VGA_CNT_W-1:0] hcount_o,
  output logic [VGA_CNT_W-1:0] vcount_o,
  output logic                 blank_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 pix_en_o,
  output logic                 frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]           frame_cnt_o
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam vga_cnt_t CntOne     = vga_cnt_t'(1);
  localparam vga_cnt_t HLast      = vga_cnt_t'(H_TOTAL - 1);
  localparam vga_cnt_t VLast      = vga_cnt_t'(V_TOTAL - 1);
  localparam vga_cnt_t HVis       = vga_cnt_t'(H_VISIBLE);
  localparam vga_cnt_t VVis       = vga_cnt_t'(V_VISIBLE);
  localparam vga_cnt_t HSyncFirst = vga_cnt_t'(H_VISIBLE + H_FRONT);
  localparam vga_cnt_t HSyncLast  = vga_cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam vga_cnt_t VSyncFirst = vga_cnt_t'(V_VISIBLE + V_FRONT);
  localparam vga_cnt_t VSyncLast  = vga_cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam vga_ctrl_t CtrlReset = '{blank: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

  logic      tick;
  vga_cnt_t  hcount_q, hcount_d;
  vga_cnt_t  vcount_q, vcount_d;
  vga_ctrl_t ctrl_q, ctrl_d;
  logic      pix_en_q;
  logic      frame_start_q, frame_start_d;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + CntOne;
      end else begin
        hcount_d = hcount_q + CntOne;
      end
    end
  end

  // Decode from the next counter values so the registered flags line up with the counters.
  always_comb begin
    ctrl_d.blank  = (hcount_d >= HVis) || (vcount_d >= VVis);
    ctrl_d.hsync  = in_window(hcount_d, HSyncFirst, HSyncLast) ? HSYNC_POL : ~HSYNC_POL;
    ctrl_d.vsync  = in_window(vcount_d, VSyncFirst, VSyncLast) ? VSYNC_POL : ~VSYNC_POL;
    frame_start_d = tick && (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      ctrl_q        <= CtrlReset;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      ctrl_q        <= ctrl_d;
      pix_en_q      <= tick;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign blank_o       = ctrl_q.blank;
  assign hsync_o       = ctrl_q.hsync;
  assign vsync_o       = ctrl_q.vsync;
  assign pix_en_o      = pix_en_q;
  assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Reads N during the N-th frame_start pulse, then advances.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_q) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-geometry instances (CLK_DIV 2 and 1) against an
// arithmetic raster model driven by elapsed cycles since reset.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [9:0] h0, v0, h1, v1;
  logic       bl0, hs0, vs0, pe0, fs0;
  logic       bl1, hs1, vs1, pe1, fs1;
  logic [7:0] fc0, fc1;

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;
  int last_fs [2];
  bit have_fs [2];
  int nfs [2];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut0 (
    .clk(clk), .reset(reset), .hcount_o(h0), .vcount_o(v0), .blank_o(bl0),
    .hsync_o(hs0), .vsync_o(vs0), .pix_en_o(pe0), .frame_start_o(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_o(fc0)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut1 (
    .clk(clk), .reset(reset), .hcount_o(h1), .vcount_o(v1), .blank_o(bl1),
    .hsync_o(hs1), .vsync_o(vs1), .pix_en_o(pe1), .frame_start_o(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_o(fc1)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // Model: after t post-reset edges, floor(t/d) pixel advances have happened.
  function automatic int model_pos(input int d);
    return (t / d) % (HT * VT);
  endfunction

  task automatic check_dut(input string tag, input int idx, input int d,
                           input logic [9:0] h, input logic [9:0] v, input logic bl,
                           input logic hs, input logic vs, input logic pe, input logic fs,
                           input logic [7:0] fc);
    int pos, eh, ev;
    logic ebl, ehs, evs, epe, efs;
    pos = model_pos(d);
    eh  = pos % HT;
    ev  = pos / HT;
    ebl = (eh >= HV) || (ev >= VV);
    ehs = (eh >= HV + HF && eh < HV + HF + HS) ? HPOL : !HPOL;
    evs = (ev >= VV + VF && ev < VV + VF + VS) ? VPOL : !VPOL;
    epe = (t >= 1) && (t % d == 0);
    efs = epe && (pos == 0);
    chk({tag, ".hcount"}, h, eh);
    chk({tag, ".vcount"}, v, ev);
    chk({tag, ".blank"}, bl, ebl);
    chk({tag, ".hsync"}, hs, ehs);
    chk({tag, ".vsync"}, vs, evs);
    chk({tag, ".pix_en"}, pe, epe);
    chk({tag, ".frame_start"}, fs, efs);
    if (fs) begin
      if (have_fs[idx]) chk({tag, ".frame_period"}, t - last_fs[idx], d * HT * VT);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk({tag, ".frame_cnt"}, fc, nfs[idx] % 256);
`else
      if (fc !== 8'd0) chk({tag, ".frame_cnt_tie"}, fc, 0);
`endif
      last_fs[idx] = t;
      have_fs[idx] = 1'b1;
      nfs[idx]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      t = 0;
      have_fs = '{0, 0};
      nfs = '{0, 0};
    end else begin
      t++;
    end
    @(negedge clk);
    check_dut("d2", 0, 2, h0, v0, bl0, hs0, vs0, pe0, fs0, fc0);
    check_dut("d1", 1, 1, h1, v1, bl1, hs1, vs1, pe1, fs1, fc1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pos, eh, ev, budget;
    bit found;
    have_fs = '{0, 0};
    nfs = '{0, 0};
    last_fs = '{0, 0};

    // Reset hold, release, then several full frames of the slow instance.
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);
    chk("first_tick_hcount", h0, 1);
    run(3 * 2 * HT * VT);

    // Reset while the slow instance is inside hsync mid-frame.
    found = 1'b0;
    budget = 0;
    while (!found && budget < 4 * HT * VT) begin
      step();
      budget++;
      pos = model_pos(2);
      eh = pos % HT;
      ev = pos / HT;
      found = (eh >= HV + HF) && (eh < HV + HF + HS) && (ev == VV / 2);
    end
    chk("hsync_window_reached", found, 1);
    chk("in_hsync_before_reset", hs0, HPOL);
    reset = 1'b1;
    step();
    chk("midframe_reset_hsync", hs0, !HPOL);
    chk("midframe_reset_fs", fs0, 0);
    reset = 1'b0;
    run(2 * 2 * HT * VT + 7);

    // Random run lengths with random reset pulses.
    for (int k = 0; k < 30; k++) begin
      run($urandom_range(1, 1300));
      reset = 1'b1;
      run($urandom_range(1, 3));
      reset = 1'b0;
    end
    run(2 * HT * VT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
